// File: rtl/entrada_saida_param.sv
// Processor I/O unit: latches the CPU output word, converts it to decimal with a
// serial double-dabble engine and drives seven-segment digits; also services CPU input with a stall/confirm handshake.
module entrada_saida_param #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int SIGNED_MODE = 0,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  out_we,
  input  logic [WIDTH-1:0]      out_data,
  input  logic                  in_req,
  input  logic [WIDTH-1:0]      switches,
  input  logic                  confirm,
  output logic [WIDTH-1:0]      in_data,
  output logic                  in_valid,
  output logic                  in_wait,
  output logic                  busy,
  output logic                  overflow,
  output logic                  minus,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int NI = (WIDTH * 3) / 10 + 1;
  localparam int NW = (NI > DIGITS) ? NI : DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  // Inverting a zero-extended 7'h3F gives 7'h40 ("0") in digit 0 and blanks above.
  localparam logic [7*DIGITS-1:0] SEG_RESET = ~((7*DIGITS)'(7'h3F));

  typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_DONE} conv_state_e;
  typedef enum logic [1:0] {IN_WAIT_REQ, IN_WAIT_BTN, IN_CAPTURE, IN_RELEASE} in_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  conv_state_e         conv_state_q;
  logic [CW-1:0]       cnt_q;
  logic [4*NI-1:0]     bcd_q;
  logic [WIDTH-1:0]    bin_q;
  logic                sign_q;
  logic                busy_q;
  logic [7*DIGITS-1:0] seg_q;
  logic                ovf_q;
  logic                minus_q;

  logic [WIDTH-1:0]    mag_d;
  logic                neg_d;
  logic [4*NI-1:0]     bcd_adj_d;
  logic [4*NW-1:0]     bcd_ext_d;
  logic [7*DIGITS-1:0] seg_d;
  logic                ovf_d;
  logic                leading_d;
  logic [3:0]          digit_d;

  // Most-negative input negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    neg_d = (SIGNED_MODE != 0) && out_data[WIDTH-1];
    mag_d = neg_d ? (~out_data + WIDTH'(1)) : out_data;
  end

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    bcd_adj_d = bcd_q;
    for (int i = 0; i < NI; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Display image built from the finished BCD; digits beyond NI read as zero.
  always_comb begin
    bcd_ext_d = '0;
    bcd_ext_d[4*NI-1:0] = bcd_q;
    ovf_d = 1'b0;
    for (int i = DIGITS; i < NW; i++) begin
      if (bcd_ext_d[4*i +: 4] != 4'd0) ovf_d = 1'b1;
    end
    leading_d = (BLANK_ZEROS != 0);
    digit_d   = 4'd0;
    seg_d     = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit_d = bcd_ext_d[4*i +: 4];
      if (ovf_d) begin
        seg_d[7*i +: 7] = 7'h3F;
      end else if (leading_d && digit_d == 4'd0 && i != 0) begin
        seg_d[7*i +: 7] = 7'h7F;
      end else begin
        leading_d = 1'b0;
        seg_d[7*i +: 7] = seg_decode(digit_d);
      end
    end
  end

  // The load step happens on the write edge itself, so a write in any state restarts SHIFT.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking '<=' and a synchronous reset that clears every register, datapath included.
    if (reset) begin
      conv_state_q <= CONV_IDLE;
      cnt_q        <= '0;
      bcd_q        <= '0;
      bin_q        <= '0;
      sign_q       <= 1'b0;
      busy_q       <= 1'b0;
      seg_q        <= SEG_RESET;
      ovf_q        <= 1'b0;
      minus_q      <= 1'b0;
    end else if (out_we) begin
      conv_state_q <= CONV_SHIFT;
      cnt_q        <= '0;
      bcd_q        <= '0;
      bin_q        <= mag_d;
      sign_q       <= neg_d;
      busy_q       <= 1'b1;
    end else begin
      case (conv_state_q)
        CONV_SHIFT: begin
          bcd_q <= {bcd_adj_d[4*NI-2:0], bin_q[WIDTH-1]};
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_SHIFT) conv_state_q <= CONV_DONE;
        end
        CONV_DONE: begin
          seg_q        <= seg_d;
          ovf_q        <= ovf_d;
          minus_q      <= sign_q;
          busy_q       <= 1'b0;
          conv_state_q <= CONV_IDLE;
        end
        default: conv_state_q <= CONV_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign seg      = seg_q;
  assign overflow = ovf_q;
  assign minus    = minus_q;

  in_state_e        in_state_q;
  logic             conf_meta_q, conf_sync_q, conf_prev_q;
  logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0] in_data_q;
  logic             in_valid_q;
  logic             conf_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      conf_meta_q <= 1'b0;
      conf_sync_q <= 1'b0;
      conf_prev_q <= 1'b0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      conf_meta_q <= confirm;
      conf_sync_q <= conf_meta_q;
      conf_prev_q <= conf_sync_q;
      sw_meta_q   <= switches;
      sw_sync_q   <= sw_meta_q;
    end
  end

  // Only a fresh press counts: a button already held when in_req rises shows no edge.
  assign conf_rise = conf_sync_q & ~conf_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_state_q <= IN_WAIT_REQ;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      case (in_state_q)
        IN_WAIT_REQ: if (in_req) in_state_q <= IN_WAIT_BTN;
        IN_WAIT_BTN: begin
          if (!in_req) begin
            in_state_q <= IN_WAIT_REQ;
          end else if (conf_rise) begin
            in_state_q <= IN_CAPTURE;
            in_data_q  <= sw_sync_q;
            in_valid_q <= 1'b1;
          end
        end
        IN_CAPTURE:  in_state_q <= IN_RELEASE;
        IN_RELEASE:  if (!in_req) in_state_q <= IN_WAIT_REQ;
        default:     in_state_q <= IN_WAIT_REQ;
      endcase
    end
  end

  assign in_data  = in_data_q;
  assign in_valid = in_valid_q;
  assign in_wait  = ((in_state_q == IN_WAIT_REQ) && in_req) || (in_state_q == IN_WAIT_BTN);

endmodule

// File: doc/entrada_saida_param.md
Name: entrada_saida_param

Overview:
Parametrised processor I/O unit. It registers the output word the CPU writes and converts it to decimal with a sequential shift-add-3 (double-dabble) engine. It drives DIGITS active-low seven-segment displays with optional sign, leading-zero blanking and overflow indication. It also services the CPU input instruction with a stall/confirm handshake that captures the board switches.

Parameters:
WIDTH, 32, data word width (4..32)
DIGITS, 8, number of seven-segment digits driven (1..10)
SIGNED_MODE, 0, 1 = treat output word as two's complement and show sign
BLANK_ZEROS, 1, 1 = blank leading zero digits (the units digit is never blanked)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
out_we  in  1  CPU output-write strobe, one cycle
out_data  in  WIDTH  word to display, sampled when out_we=1
in_req  in  1  CPU input instruction active, held until in_valid
switches  in  WIDTH  board switch value (asynchronous)
confirm  in  1  board confirm button, active-high, asynchronous
in_data  out  WIDTH  captured switch value
in_valid  out  1  one-cycle pulse: in_data valid
in_wait  out  1  stall request to CPU
busy  out  1  conversion in progress
overflow  out  1  value magnitude does not fit in DIGITS digits
minus  out  1  sign indicator (active-high)
seg  out  7*DIGITS  digit i at [7i+6:7i], active-low, bit0=a .. bit6=g; digit 0 = units

Behaviour:
- Reset, as a synchronous result:
  - in_data=0, in_valid=0, in_wait=0, busy=0, overflow=0, minus=0.
  - All seg digits show blank (7'h7F), except digit 0, which shows "0" (7'h40).
  - Conversion FSM returns to IDLE; any conversion in progress is discarded.
  - Input FSM returns to WAIT_REQ.
- Converter FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - On out_we in any state: latch the magnitude. The magnitude is out_data, or its two's-complement negation when SIGNED_MODE=1 and the MSB is set. Latch the sign, clear the internal BCD, enter SHIFT, busy=1 from the next cycle.
  - A write during SHIFT restarts the conversion with the new value (latest write wins). The displays keep their old value until a conversion completes.
  - SHIFT: exactly WIDTH cycles. Each cycle adds 3 to every internal BCD nibble >= 5, then shifts the BCD:binary register left by 1.
  - Internal BCD has NI = (WIDTH*3)/10+1 digits, so 10 digits for WIDTH=32.
  - DONE (1 cycle): register seg, minus and overflow; busy=0. Total latency from out_we edge to updated seg = WIDTH+2 clocks.
  - SIGNED_MODE=1 with most-negative input (e.g. 32'h80000000): magnitude 2^(WIDTH-1) is computed unsigned, no wrap.
- Display rules, applied at DONE:
  - overflow=1 if any internal digit at index >= DIGITS is nonzero. All digits then show dash (7'h3F), and minus still reflects the sign.
  - Otherwise decode each digit 0-9 to standard active-low patterns: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - With BLANK_ZEROS=1, zeros above the most significant nonzero digit show 7'h7F.
  - minus=1 only if SIGNED_MODE=1, the value is negative and nonzero.
- Input path:
  - confirm passes through a 2-flop synchroniser, then rising-edge detect.
  - Input FSM: WAIT_REQ -> WAIT_BTN -> CAPTURE -> RELEASE.
  - WAIT_REQ: in_wait=0. When in_req=1, go to WAIT_BTN with in_wait=1 in the same cycle (combinational from in_req).
  - WAIT_BTN: in_wait=1. A synchronised confirm rising edge moves to CAPTURE.
  - CAPTURE: in_data <= switches (sampled through a 2-flop synchroniser); in_valid=1 for one cycle; in_wait=0.
  - RELEASE: wait for in_req=0, then return to WAIT_REQ.
  - A button already held when in_req rises is ignored; a new press is required.
  - in_req dropping in WAIT_BTN aborts back to WAIT_REQ with no in_valid.
- The output and input paths are independent and may operate in the same cycle.

Test Plan:
- Reset, then out_we with out_data=1234 (WIDTH=32, DIGITS=8, defaults):
  - busy high for 33 cycles.
  - After WIDTH+2 clocks, digits 0..3 = 30,24,79,19 (4,3,2,1 units first); digits 4..7 = 7F; overflow=0.
- out_data=100000000 (9 digits) -> overflow=1, all digits 3F.
- out_data=99999999 -> all digits 10, overflow=0.
- SIGNED_MODE=1, out_data=32'hFFFFFF85 (-123) -> minus=1, digits 0..2 = 30,24,79.
- SIGNED_MODE=1, out_data=32'h80000000 -> overflow=1, minus=1.
- Write 5, then write 7 ten cycles later -> final display "7" only, busy continuous, latency counted from the second write.
- in_req=1 with confirm already held:
  - no capture; in_wait stays 1.
  - Release confirm, then press with switches=42 -> in_data=42, in_valid one-cycle pulse, in_wait=0.
  - Drop in_req -> back to WAIT_REQ.
- Reset asserted mid-SHIFT and in WAIT_BTN -> next cycle all outputs at reset values; a subsequent write of 0 shows digit0=40 and blanks elsewhere.
